// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter_pkg
// Purpose: Shared constants and types for the fetch/data memory arbiter:
//          FSM state encoding, request-owner encoding, memory request types.
// Rev    : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Which requester owns the outstanding transaction
  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  // Memory request type encoding
  localparam logic MEMREQ_TYPE_READ  = 1'b0;
  localparam logic MEMREQ_TYPE_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter_if
// Purpose: Bundles the fetch channel, the data channel and the shared memory
//          port of the arbiter.
// Ports  : fetch  i_req_* / i_resp_*   (read-only requester)
//          data   d_req_* / d_resp_*   (read/write requester)
//          memory mem_req_* / mem_resp_*
// Modports: slave  - the arbiter's view
//           master - the environment's view (requesters + memory)
// Rev    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  // fetch channel
  logic                  i_req_valid;
  logic                  i_req_ready;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic                  i_resp_valid;
  logic [DATA_WIDTH-1:0] i_resp_data;

  // data channel
  logic                  d_req_valid;
  logic                  d_req_ready;
  logic [ADDR_WIDTH-1:0] d_req_addr;
  logic                  d_req_type;
  logic [DATA_WIDTH-1:0] d_req_wdata;
  logic [MASK_WIDTH-1:0] d_req_wmask;
  logic                  d_resp_valid;
  logic [DATA_WIDTH-1:0] d_resp_data;

  // shared memory port
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_type;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [MASK_WIDTH-1:0] mem_req_wmask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_valid, d_req_addr, d_req_type, d_req_wdata, d_req_wmask,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_type, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_data,
    output d_req_valid, d_req_addr, d_req_type, d_req_wdata, d_req_wmask,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_type, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_grant.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_grant
// Purpose: Chooses which requester wins the memory port when the arbiter is
//          idle. With both requesting, the one not granted last wins; a lone
//          requester always wins. Tying last_owner to OWNER_FETCH yields fixed
//          data-channel priority.
// Ports  : fetch_valid, data_valid (in)  - pending requests
//          last_owner              (in)  - previously granted requester
//          grant_owner             (out) - winner (don't-care if none valid)
// Rev    : 1.0  initial release
// ============================================================================
module mem_arb_grant
  import mem_arbiter_pkg::*;
(
  input  logic   fetch_valid,
  input  logic   data_valid,
  input  owner_e last_owner,
  output owner_e grant_owner
);

  always_comb begin
    grant_owner = OWNER_DATA;
    if (fetch_valid && data_valid) begin
      grant_owner = (last_owner == OWNER_DATA) ? OWNER_FETCH : OWNER_DATA;
    end else if (fetch_valid) begin
      grant_owner = OWNER_FETCH;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Purpose: Two-requester (instruction fetch / data) arbiter onto a single
//          memory port, one transaction outstanding at a time.
//          IDLE -> grant + capture -> REQ (hold request until accepted)
//          -> WAIT (pass response through to owner) -> IDLE.
// Ports  : clk   - clock, rising edge
//          rst   - asynchronous reset, ACTIVE LOW
//          bus   - mem_arbiter_if.slave (fetch, data and memory channels)
//          busy  - high whenever the FSM is not in IDLE
// Config : MEM_ARB_RR_EN - when defined, simultaneous requests alternate
//          (last_owner register); otherwise the data channel always wins.
// Rev    : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus,
  output logic           busy
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  type_q, type_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  busy_q, busy_d;
  // Goes high on the first edge after reset release so that no grant can be
  // offered in the cycle in which reset is deasserted.
  logic                  active_q;

  owner_e                last_owner;
  owner_e                grant_owner;
  logic                  accept;
  logic                  resp_fire;

  mem_arb_grant u_grant (
    .fetch_valid (bus.i_req_valid),
    .data_valid  (bus.d_req_valid),
    .last_owner  (last_owner),
    .grant_owner (grant_owner)
  );

  assign accept = active_q && (state_q == ST_IDLE) &&
                  (bus.i_req_valid || bus.d_req_valid);

`ifdef MEM_ARB_RR_EN
  owner_e last_owner_q, last_owner_d;

  always_comb begin
    last_owner_d = last_owner_q;
    if (accept) begin
      last_owner_d = grant_owner;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q <= OWNER_FETCH;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

  assign last_owner = last_owner_q;
`else
  // Constant "fetch was last" makes the grant unit prefer data on a tie.
  assign last_owner = OWNER_FETCH;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    type_d  = type_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant_owner;
          state_d = ST_REQ;
          if (grant_owner == OWNER_DATA) begin
            addr_d  = bus.d_req_addr;
            type_d  = bus.d_req_type;
            wdata_d = bus.d_req_wdata;
            wmask_d = bus.d_req_wmask;
          end else begin
            addr_d  = bus.i_req_addr;
            type_d  = MEMREQ_TYPE_READ;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    mem_valid_d = (state_d == ST_REQ);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_FETCH;
      addr_q      <= '0;
      type_q      <= MEMREQ_TYPE_READ;
      wdata_q     <= '0;
      wmask_q     <= '0;
      mem_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      type_q      <= type_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      mem_valid_q <= mem_valid_d;
      busy_q      <= busy_d;
      active_q    <= 1'b1;
    end
  end

  // Request side
  assign bus.i_req_ready   = accept && (grant_owner == OWNER_FETCH);
  assign bus.d_req_ready   = accept && (grant_owner == OWNER_DATA);
  assign bus.mem_req_valid = mem_valid_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_type  = type_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_req_wmask = wmask_q;

  // Response side: only a response arriving in WAIT is forwarded, and only
  // to the owner; data is forced to zero whenever the valid is low.
  assign resp_fire        = (state_q == ST_WAIT) && bus.mem_resp_valid;
  assign bus.i_resp_valid = resp_fire && (owner_q == OWNER_FETCH);
  assign bus.d_resp_valid = resp_fire && (owner_q == OWNER_DATA);
  assign bus.i_resp_data  = bus.i_resp_valid ? bus.mem_resp_data : '0;
  assign bus.d_resp_data  = bus.d_resp_valid ? bus.mem_resp_data : '0;

  assign busy = busy_q;

endmodule
`default_nettype wire
